// File: rtl/ssd1306_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Module : ssd1306_spi_tx_if
// Desc   : Host push port, FIFO status and SSD1306 SPI pins for ssd1306_spi_tx.
// Rev    : 1.0
// ============================================================================
interface ssd1306_spi_tx_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_i;
    logic          dc_i;
    logic [7:0]    data_i;
    logic          full_o;
    logic          empty_o;
    logic [LW-1:0] level_o;
    logic          busy_o;
    logic          ovf_o;
    logic          ss_o;
    logic          scl_o;
    logic          mosi_o;
    logic          dc_o;

    modport master (
        output wr_i, dc_i, data_i,
        input  full_o, empty_o, level_o, busy_o, ovf_o,
        input  ss_o, scl_o, mosi_o, dc_o
    );

    modport slave (
        input  wr_i, dc_i, data_i,
        output full_o, empty_o, level_o, busy_o, ovf_o,
        output ss_o, scl_o, mosi_o, dc_o
    );
endinterface

`default_nettype wire

// File: rtl/ssd1306_spi_tx.sv
`default_nettype none
// ============================================================================
// Module : ssd1306_spi_tx
// Desc   : FIFO-fed SPI mode-0 transmitter driving SSD1306 ss/scl/mosi/dc.
// Rev    : 1.0
// ============================================================================
module ssd1306_spi_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ssd1306_spi_tx_if.slave bus
);
    localparam int LW   = $clog2(FIFO_DEPTH) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] c_DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic          r_ovf, r_busy;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [7:0]    r_sh, w_sh_n;
    logic          r_ss, w_ss_n;
    logic          r_scl, w_scl_n;
    logic          r_mosi, w_mosi_n;
    logic          r_dc, w_dc_n;

    logic          w_full, w_empty, w_push, w_pop;
    logic [8:0]    w_head;

    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = bus.wr_i & ~w_full;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.dc_i, bus.data_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // A write against a full FIFO is lost even if a pop frees a slot this cycle.
            if (bus.wr_i && w_full) r_ovf <= 1'b1;
            r_busy <= (r_state != ST_IDLE) || !w_empty;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_sh_n    = r_sh;
        w_ss_n    = r_ss;
        w_scl_n   = r_scl;
        w_mosi_n  = r_mosi;
        w_dc_n    = r_dc;
        w_pop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ss_n  = 1'b1;
                w_scl_n = 1'b0;
                w_pop   = ~w_empty;
            end
            ST_SETUP: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_n   = '0;
                    w_scl_n   = 1'b1;
                    w_bit_n   = '0;
                    w_state_n = ST_SHIFT;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_n = '0;
                    if (r_scl) begin
                        // Falling edge: present the next bit; bit0 is held after the last fall.
                        w_scl_n = 1'b0;
                        if (r_bit != 3'd7) begin
                            w_sh_n   = {r_sh[6:0], 1'b0};
                            w_mosi_n = r_sh[6];
                        end
                    end else if (r_bit == 3'd7) begin
                        w_state_n = ST_GAP;
                    end else begin
                        w_scl_n = 1'b1;
                        w_bit_n = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_n = '0;
                    if (w_empty) begin
                        w_ss_n    = 1'b1;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_pop = 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        // Loading a new entry is the only place dc changes.
        if (w_pop) begin
            w_ss_n    = 1'b0;
            w_dc_n    = w_head[8];
            w_sh_n    = w_head[7:0];
            w_mosi_n  = w_head[7];
            w_cnt_n   = '0;
            w_state_n = ST_SETUP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_ss    <= 1'b1;
            r_scl   <= 1'b0;
            r_mosi  <= 1'b0;
            r_dc    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_sh    <= w_sh_n;
            r_ss    <= w_ss_n;
            r_scl   <= w_scl_n;
            r_mosi  <= w_mosi_n;
            r_dc    <= w_dc_n;
        end
    end

    assign bus.full_o  = w_full;
    assign bus.empty_o = w_empty;
    assign bus.level_o = r_level;
    assign bus.busy_o  = r_busy;
    assign bus.ovf_o   = r_ovf;
    assign bus.ss_o    = r_ss;
    assign bus.scl_o   = r_scl;
    assign bus.mosi_o  = r_mosi;
    assign bus.dc_o    = r_dc;
endmodule

`default_nettype wire

// File: tb/tb_ssd1306_spi_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_ssd1306_spi_tx
// Desc   : Directed self-checking bench for ssd1306_spi_tx (CLK_DIV=2 and 1).
// Rev    : 1.0
// ============================================================================
module tb_ssd1306_spi_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ssd1306_spi_tx_if #(.FIFO_DEPTH(16)) bus0 ();
    ssd1306_spi_tx_if #(.FIFO_DEPTH(16)) bus1 ();

    ssd1306_spi_tx #(.CLK_DIV(2), .FIFO_DEPTH(16), .GAP_CYCLES(4)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    ssd1306_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(16), .GAP_CYCLES(4)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SPI-side monitor on dut0: samples mosi at each scl rise, queues {dc, byte}.
    logic [8:0] rxq[$];
    int         mon_bits  = 0;
    int         n_rise    = 0;
    int         n_dcviol  = 0;
    logic [7:0] mon_sh    = '0;
    logic       mon_pscl  = 1'b0;
    logic       mon_pdc   = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus0.ss_o) begin
                mon_bits = 0;
            end else begin
                if (bus0.scl_o && !mon_pscl) begin
                    mon_sh = {mon_sh[6:0], bus0.mosi_o};
                    mon_bits++;
                    n_rise++;
                    if (mon_bits == 8) begin
                        rxq.push_back({bus0.dc_o, mon_sh});
                        mon_bits = 0;
                    end
                end
                if (bus0.dc_o != mon_pdc && mon_bits != 0) n_dcviol++;
            end
            mon_pscl = bus0.scl_o;
            mon_pdc  = bus0.dc_o;
        end
    end

    task automatic wait_idle0();
        int n = 0;
        while ((bus0.busy_o || !bus0.empty_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    int         i, first_rise, dc_chg, r0, n, rises, highs;
    logic       pscl;
    logic [7:0] rx;

    initial begin
        bus0.wr_i = 1'b0; bus0.dc_i = 1'b0; bus0.data_i = 8'h00;
        bus1.wr_i = 1'b0; bus1.dc_i = 1'b0; bus1.data_i = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_flags", {bus0.ss_o, bus0.scl_o, bus0.mosi_o, bus0.dc_o,
                              bus0.full_o, bus0.empty_o, bus0.busy_o, bus0.ovf_o}, 8'b1000_0100);
        check("reset_level", bus0.level_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single data byte 0xA5
        rxq.delete(); r0 = n_rise;
        bus0.wr_i = 1'b1; bus0.dc_i = 1'b1; bus0.data_i = 8'hA5;
        @(negedge clk);
        bus0.wr_i = 1'b0;
        check("t1_after_E0", {bus0.empty_o, bus0.ss_o}, 2'b01);
        check("t1_level_E0", bus0.level_o, 1);
        @(negedge clk);
        check("t1_load_E1", {bus0.ss_o, bus0.dc_o, bus0.mosi_o, bus0.empty_o}, 4'b0111);
        i = 0; first_rise = -1;
        while (!bus0.ss_o && i < 400) begin
            @(negedge clk); i++;
            if (bus0.scl_o && first_rise < 0) first_rise = i;
        end
        check("t1_ss_low_len", i, 38);
        check("t1_first_rise", first_rise, 2);
        check("t1_busy_at_ss_rise", bus0.busy_o, 1);
        @(negedge clk);
        check("t1_busy_drop", bus0.busy_o, 0);
        check("t1_rises", n_rise - r0, 8);
        check("t1_rx_count", rxq.size(), 1);
        check("t1_rx_byte", rxq[0], {1'b1, 8'hA5});

        // Command 0xAF then data 0x3C back-to-back
        rxq.delete();
        bus0.wr_i = 1'b1; bus0.dc_i = 1'b0; bus0.data_i = 8'hAF;
        @(negedge clk);
        bus0.dc_i = 1'b1; bus0.data_i = 8'h3C;
        @(negedge clk);
        bus0.wr_i = 1'b0;
        check("t2_load_E1", {bus0.ss_o, bus0.dc_o, bus0.mosi_o}, 3'b001);
        check("t2_level_E1", bus0.level_o, 1);
        i = 0; dc_chg = -1;
        while (!bus0.ss_o && i < 400) begin
            @(negedge clk); i++;
            if (bus0.dc_o && dc_chg < 0) dc_chg = i;
        end
        check("t2_ss_low_len", i, 76);
        check("t2_dc_change", dc_chg, 38);
        check("t2_rx_count", rxq.size(), 2);
        check("t2_rx0", rxq[0], {1'b0, 8'hAF});
        check("t2_rx1", rxq[1], {1'b1, 8'h3C});
        wait_idle0();

        // 18 consecutive writes into a 16-deep FIFO
        rxq.delete();
        for (int k = 0; k < 18; k++) begin
            bus0.wr_i = 1'b1; bus0.dc_i = k[0]; bus0.data_i = 8'h10 + 8'(k);
            @(negedge clk);
            if (k == 15) check("t3_not_full_E15", bus0.full_o, 0);
            if (k == 16) begin
                check("t3_full_E16", {bus0.full_o, bus0.ovf_o}, 2'b10);
                check("t3_level_E16", bus0.level_o, 16);
            end
            if (k == 17) begin
                check("t3_ovf_E17", bus0.ovf_o, 1);
                check("t3_level_E17", bus0.level_o, 16);
            end
        end
        bus0.wr_i = 1'b0;
        wait_idle0();
        check("t3_rx_count", rxq.size(), 17);
        for (int j = 0; j < 17; j++) begin
            check($sformatf("t3_rx%0d", j), rxq[j], {j[0], 8'h10 + 8'(j)});
        end
        check("t3_ovf_sticky", bus0.ovf_o, 1);

        // Reset during bit 3 with 5 entries queued
        for (int k = 0; k < 6; k++) begin
            bus0.wr_i = 1'b1; bus0.dc_i = 1'b1; bus0.data_i = 8'h40 + 8'(k);
            @(negedge clk);
        end
        bus0.wr_i = 1'b0;
        n = 0;
        while (mon_bits < 4 && n < 200) begin
            @(negedge clk); n++;
        end
        check("t4_pre_reset", {bus0.ss_o, 3'(bus0.level_o)}, {1'b0, 3'd5});
        rst = 1'b1;
        #1;
        check("t4_async_reset", {bus0.ss_o, bus0.scl_o, bus0.ovf_o, bus0.empty_o}, 4'b1001);
        check("t4_level_reset", bus0.level_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rxq.delete(); r0 = n_rise;
        bus0.wr_i = 1'b1; bus0.dc_i = 1'b0; bus0.data_i = 8'h5A;
        @(negedge clk);
        bus0.wr_i = 1'b0;
        wait_idle0();
        check("t4_rises", n_rise - r0, 8);
        check("t4_rx_count", rxq.size(), 1);
        check("t4_rx_byte", rxq[0], {1'b0, 8'h5A});
        check("dc_stable_in_byte", n_dcviol, 0);

        // CLK_DIV=1 instance
        bus1.wr_i = 1'b1; bus1.dc_i = 1'b1; bus1.data_i = 8'hC3;
        @(negedge clk);
        bus1.wr_i = 1'b0;
        @(negedge clk);
        check("t5_load_E1", {bus1.ss_o, bus1.mosi_o}, 2'b01);
        i = 0; rises = 0; highs = 0; pscl = 1'b0; rx = '0; first_rise = -1;
        while (!bus1.ss_o && i < 200) begin
            @(negedge clk); i++;
            if (bus1.scl_o) begin
                highs++;
                if (first_rise < 0) first_rise = i;
                if (!pscl) begin
                    rises++;
                    rx = {rx[6:0], bus1.mosi_o};
                end
            end
            pscl = bus1.scl_o;
        end
        check("t5_ss_low_len", i, 21);
        check("t5_first_rise", first_rise, 1);
        check("t5_high_cycles", highs, 8);
        check("t5_rises", rises, 8);
        check("t5_rx_byte", rx, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
